// File: rtl/uart_rx.sv
// uart_rx: UART receiver (8N1 by default) with a small receive FIFO and a memory-mapped read port.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int  DW         = 8,
  parameter real CLOCK      = 100e6,
  parameter int  BAUD_RATE  = 9600,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        cs,
  input  logic        re,
  input  logic        addr_i,
  output logic [31:0] rdata_o,
  output logic        rx_avail_o
);

  localparam int CLKS_PER_BIT = $rtoi(CLOCK / BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW           = (DW > 1) ? $clog2(DW) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PW           = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic           r_sync1;
  logic           r_rxS;
  logic           r_rxPrev;
  state_t         r_state;
  state_t         w_nextState;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_bitIdx;
  logic [DW-1:0]  r_shift;
  logic           w_fall;
  logic           w_bitEnd;
  logic           w_cntClr;
  logic           w_sample;
  logic           w_push;
  logic           w_frameErrSet;
  logic           w_parityErr;

  logic [DW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wrPtr;
  logic [AW:0]    r_rdPtr;
  logic           w_empty;
  logic           w_full;
  logic           w_dataRead;
  logic           w_statRead;
  logic           w_pop;
  logic           w_doPush;
  logic           w_overrunSet;
  logic           r_overrun;
  logic           r_frameErr;

  // Two-flop synchronizer; preset high so reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1  <= 1'b1;
      r_rxS    <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= rx_i;
      r_rxS    <= r_sync1;
      r_rxPrev <= r_rxS;
    end
  end

  assign w_fall   = r_rxPrev & ~r_rxS;
  assign w_bitEnd = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntClr ? '0 : r_cnt + CW'(1);
      if (r_state == S_START)
        r_bitIdx <= '0;
      else if (w_sample)
        r_bitIdx <= r_bitIdx + IW'(1);
      if (w_sample)
        r_shift <= {r_rxS, r_shift[DW-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_parErrSet;
  logic r_parBad;
  logic r_parityErr;
`endif

  always_comb begin
    w_nextState   = r_state;
    w_cntClr      = 1'b0;
    w_sample      = 1'b0;
    w_push        = 1'b0;
    w_frameErrSet = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parErrSet   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cntClr = 1'b1;
        if (w_fall)
          w_nextState = S_START;
      end
      S_START: begin
        if (r_cnt == CW'(HALF_BIT - 1)) begin
          w_cntClr    = 1'b1;
          w_nextState = r_rxS ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_cntClr = 1'b1;
          w_sample = 1'b1;
          if (r_bitIdx == IW'(DW - 1))
`ifdef UART_RX_PARITY_EN
            w_nextState = S_PARITY;
`else
            w_nextState = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bitEnd) begin
          w_cntClr    = 1'b1;
          w_parErrSet = (r_rxS != ^r_shift);
          w_nextState = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bitEnd) begin
          w_cntClr    = 1'b1;
          w_nextState = S_IDLE;
          if (r_rxS)
`ifdef UART_RX_PARITY_EN
            w_push = ~r_parBad;
`else
            w_push = 1'b1;
`endif
          else
            w_frameErrSet = 1'b1;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // A bad parity bit poisons the frame until its stop bit decides whether to push.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_parBad    <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      if (r_state == S_PARITY && w_bitEnd)
        r_parBad <= w_parErrSet;
      r_parityErr <= w_parErrSet | (r_parityErr & ~w_statRead);
    end
  end

  assign w_parityErr = r_parityErr;
`else
  assign w_parityErr = 1'b0;
`endif

  assign w_empty      = (r_wrPtr == r_rdPtr);
  assign w_full       = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign rx_avail_o   = ~w_empty;
  assign w_dataRead   = cs & re & ~addr_i;
  assign w_statRead   = cs & re & addr_i;
  assign w_pop        = w_dataRead & ~w_empty;
  assign w_doPush     = w_push & (~w_full | w_pop);
  assign w_overrunSet = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_doPush)
      r_mem[r_wrPtr[AW-1:0]] <= r_shift;
  end

  // A status read clears the sticky errors, but an error raised on the same edge survives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      rdata_o    <= '0;
    end else begin
      if (w_doPush)
        r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + PW'(1);
      r_overrun  <= w_overrunSet | (r_overrun & ~w_statRead);
      r_frameErr <= w_frameErrSet | (r_frameErr & ~w_statRead);
      if (w_dataRead)
        rdata_o <= w_empty ? 32'd0 : {{(32-DW){1'b0}}, r_mem[r_rdPtr[AW-1:0]]};
      else if (w_statRead)
        rdata_o <= {27'd0, w_parityErr, r_frameErr, r_overrun, w_full, ~w_empty};
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scenario tests plus randomized frames for uart_rx, checked against a queue-based model.
// Runs with CLOCK=16, BAUD_RATE=1 so one bit lasts 16 clocks; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit parityOn = 1'b1;
`else
  localparam bit parityOn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i  = 1'b1;
  logic        cs    = 1'b0;
  logic        re    = 1'b0;
  logic        addr_i = 1'b0;
  logic [31:0] rdata_o;
  logic        rx_avail_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       mOver  = 1'b0;
  logic       mFrame = 1'b0;
  logic       mPar   = 1'b0;

  uart_rx #(.DW(8), .CLOCK(16.0), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .cs(cs), .re(re),
    .addr_i(addr_i), .rdata_o(rdata_o), .rx_avail_o(rx_avail_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: what the receiver should conclude about one complete frame.
  task automatic modelFrame(input logic [7:0] data, input logic stopBit, input logic parBit);
    logic parBad;
    parBad = parityOn && (parBit != ^data);
    if (parBad) mPar = 1'b1;
    if (!stopBit) mFrame = 1'b1;
    else if (!parBad) begin
      if (mq.size() == 4) mOver = 1'b1;
      else mq.push_back(data);
    end
  endtask

  task automatic modelRead(input logic a, output logic [31:0] e);
    if (a) begin
      e = {27'd0, mPar, mFrame, mOver, mq.size() == 4, mq.size() != 0};
      mPar = 1'b0; mFrame = 1'b0; mOver = 1'b0;
    end else if (mq.size() == 0) e = 32'd0;
    else e = {24'd0, mq.pop_front()};
  endtask

  task automatic modelReset();
    mq.delete();
    mOver = 1'b0; mFrame = 1'b0; mPar = 1'b0;
  endtask

  task automatic doRead(input logic a, output logic [31:0] d);
    @(negedge clk_i);
    cs = 1'b1; re = 1'b1; addr_i = a;
    @(negedge clk_i);
    cs = 1'b0; re = 1'b0;
    d = rdata_o;
  endtask

  task automatic sendHead(input logic [7:0] data, input logic parBit);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      repeat (BIT) @(negedge clk_i);
    end
    if (parityOn) begin
      rx_i = parBit;
      repeat (BIT) @(negedge clk_i);
    end
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopBit, input logic parBit);
    sendHead(data, parBit);
    rx_i = stopBit;
    repeat (BIT) @(negedge clk_i);
    rx_i = 1'b1;
    if (!stopBit) repeat (BIT) @(negedge clk_i);
    modelFrame(data, stopBit, parBit);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    repeat (3) @(negedge clk_i);
    checks++;
    if (rdata_o !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata_o, 32'd0);
    end
    checks++;
    if (rx_avail_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_avail: got %b expected 0", rx_avail_o);
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL reset_status: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] got, exp;
    int waitCnt;
    sendHead(8'hA5, ^8'hA5);
    rx_i = 1'b1;
    waitCnt = 0;
    while (!rx_avail_o && waitCnt < BIT) begin
      @(negedge clk_i); waitCnt++;
    end
    checks++;
    if (!(rx_avail_o === 1'b1 && waitCnt <= 12)) begin
      errors++; $display("[TB] FAIL avail_rise: avail %b after %0d cycles, required 1 within 12", rx_avail_o, waitCnt);
    end
    repeat (BIT - waitCnt) @(negedge clk_i);
    modelFrame(8'hA5, 1'b1, ^8'hA5);
    doRead(1'b0, got); modelRead(1'b0, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL rxdata_a5: got %h expected %h", got, exp);
    end
    checks++;
    if (rx_avail_o !== (mq.size() != 0)) begin
      errors++; $display("[TB] FAIL avail_fall: got %b expected %b", rx_avail_o, mq.size() != 0);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] got, exp;
    for (int i = 1; i <= 5; i++) sendFrame(8'(i), 1'b1, ^8'(i));
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL overrun_status: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      doRead(1'b0, got); modelRead(1'b0, exp);
      checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL overrun_data%0d: got %h expected %h", i, got, exp);
      end
    end
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL overrun_status_clear: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_frame_error();
    logic [31:0] got, exp;
    sendFrame(8'h3C, 1'b0, ^8'h3C);
    checks++;
    if (rx_avail_o !== 1'b0) begin
      errors++; $display("[TB] FAIL frame_err_nopush: avail %b expected 0", rx_avail_o);
    end
    for (int i = 0; i < 2; i++) begin
      doRead(1'b1, got); modelRead(1'b1, exp);
      checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL frame_err_status%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] got, exp;
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (2 * BIT) @(negedge clk_i);
    checks++;
    if (rx_avail_o !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch_avail: got %b expected 0", rx_avail_o);
    end
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL glitch_status: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_break();
    logic [31:0] got, exp;
    rx_i = 1'b0;
    repeat (11 * BIT) @(negedge clk_i);
    modelFrame(8'h00, 1'b0, 1'b0);
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL break_status: got %h expected %h", got, exp);
    end
    repeat (3 * BIT) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (2 * BIT) @(negedge clk_i);
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL break_single_error: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] got, exp;
    logic [7:0] pre;
    pre = 8'($urandom) | 8'h01;
    sendFrame(pre, 1'b1, ^pre);
    doRead(1'b0, got); modelRead(1'b0, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL pre_reset_data: got %h expected %h", got, exp);
    end
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (3 * BIT + BIT / 2) @(negedge clk_i);
    rst_i = 1'b1;
    modelReset();
    @(negedge clk_i);
    checks++;
    if (rdata_o !== 32'd0 || rx_avail_o !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_reset: rdata %h avail %b expected 0 and 0", rdata_o, rx_avail_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2 * BIT) @(negedge clk_i);
    sendFrame(8'h5A, 1'b1, ^8'h5A);
    for (int i = 0; i < 2; i++) begin
      doRead(1'b0, got); modelRead(1'b0, exp);
      checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL after_reset_data%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] got, exp;
    sendFrame(8'h07, 1'b1, 1'b0);
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL parity_bad_status: got %h expected %h", got, exp);
    end
    sendFrame(8'h07, 1'b1, 1'b1);
    doRead(1'b0, got); modelRead(1'b0, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL parity_good_data: got %h expected %h", got, exp);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    logic [7:0] data;
    logic stopBit, parBit, a;
    for (int n = 0; n < 10; n++) begin
      data    = 8'($urandom);
      stopBit = ($urandom_range(0, 4) != 0);
      parBit  = ($urandom_range(0, 5) != 0) ? ^data : ~^data;
      sendFrame(data, stopBit, parBit);
      checks++;
      if (rx_avail_o !== (mq.size() != 0)) begin
        errors++; $display("[TB] FAIL random_avail%0d: got %b expected %b", n, rx_avail_o, mq.size() != 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        a = 1'($urandom_range(0, 1));
        doRead(a, got); modelRead(a, exp);
        checks++;
        if (got !== exp) begin
          errors++; $display("[TB] FAIL random_read%0d addr %b: got %h expected %h", n, a, got, exp);
        end
      end
    end
    doRead(1'b1, got); modelRead(1'b1, exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("[TB] FAIL random_status: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      doRead(1'b0, got); modelRead(1'b0, exp);
      checks++;
      if (got !== exp) begin
        errors++; $display("[TB] FAIL random_drain%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver peripheral: the receive-side counterpart of the core's transmit path, sitting behind the peripheral bus alongside data memory and the UART transmitter.
- Samples serial line `rx_i` (8N1 by default), assembles bytes LSB-first and buffers them in a small FIFO.
- The core reads bytes and sticky status through a memory-mapped read port selected by the peripheral bus chip select.

Parameters:
- DW, 8, data bits per frame.
- CLOCK, 100e6, system clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.
- Derived, local: CLKS_PER_BIT = CLOCK/BAUD_RATE, integer-truncated; HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_i  in  1  serial line, asynchronous; idles high.
- cs  in  1  chip select from peripheral bus.
- re  in  1  read enable; a read occurs when cs & re.
- addr_i  in  1  register select: 0 = RXDATA, 1 = STATUS.
- rdata_o  out  32  read data, registered.
- rx_avail_o  out  1  FIFO not empty; usable as interrupt request.

Behaviour:
- Reset:
  - FSM = IDLE, FIFO empty, all sticky flags 0.
  - rdata_o = 0, rx_avail_o = 0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame; no byte is pushed.
- Input path: rx_i passes through a 2-FF synchronizer (rx_s). A falling edge is detected on rx_s against its 1-cycle-delayed copy.
- FSM states:
  - IDLE: on falling edge, clear counter, go to START.
  - START: count to HALF_BIT-1, then sample rx_s.
    - 0: clear counter and bit index, go to DATA.
    - 1: glitch; return to IDLE with no flag set.
  - DATA: every CLKS_PER_BIT cycles, sample into shift register LSB-first. After bit DW-1, go to PARITY if enabled, else STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: push byte.
    - 0: set frame_err sticky and discard byte.
    - Either case: return to IDLE.
  - A new frame is only detected after IDLE sees a fresh falling edge, so a held-low line (break) yields exactly one frame error.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; wrap-around by natural overflow.
  - Full when pointers differ only in MSB.
  - Push when full: byte dropped, overrun sticky set.
  - Push and pop in the same cycle while full: both occur; no overrun.
  - Pop when empty: no effect.
- Read port (one-cycle latency; rdata_o updates on the edge after cs & re):
  - RXDATA: returns {24'b0, head byte} and pops the head. If empty, returns 0 and does not pop.
  - STATUS: returns bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err (0 when feature absent), other bits 0. Reading STATUS clears bits 2–4 on the same edge. If a new error occurs in that same cycle, the set wins.
  - No read in a cycle: rdata_o holds its value.
- rx_avail_o is combinational from pointer compare.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one bit after CLKS_PER_BIT cycles.
  - Even parity is checked over the data bits.
  - On mismatch: parity_err sticky set and the byte is discarded, even if the stop bit is good.
- Undefined:
  - No PARITY state; frame is 8N1.
  - STATUS bit4 is constant 0.

Test Plan (CLOCK=16, BAUD_RATE=1 → CLKS_PER_BIT=16):
- Frame 0xA5 sent with good stop bit -> rx_avail_o rises within 2 cycles after the stop sample; RXDATA read returns 0x000000A5; rx_avail_o falls.
- 5 frames 0x01..0x05 with no reads -> STATUS = 0x07 (not_empty, full, overrun); four RXDATA reads return 0x01..0x04; next STATUS read = 0x00.
- Frame 0x3C with stop bit driven 0 -> no push; STATUS = 0x08; a second STATUS read = 0x00.
- Low glitch on rx_i lasting 4 cycles -> FSM returns to IDLE; FIFO empty; STATUS = 0x00.
- rst_i asserted at data bit 3 of frame 0xFF, then frame 0x5A -> only 0x5A is received; rdata_o = 0 immediately after reset.
- UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> byte discarded; STATUS = 0x10. Same frame with parity bit 1 -> RXDATA returns 0x07.
